pulse_stretcher: RTL

//   Converts 1-cycle pulses (e.g. edge-detector / debouncer outputs) back into

---
 rtl/pulse_stretcher.sv | 59 +++++
 1 files changed

// File: rtl/pulse_stretcher.sv
// Per-channel pulse stretcher: each accepted 1-cycle pulse holds its channel's
// level high for hold_cycles cycles, with a registered strobe when the hold ends.
module pulse_stretcher #(
    parameter int width       = 1,
    parameter int hold_cycles = 4,
    parameter bit retrigger   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] pulse_in,
    output logic [width-1:0] level_out,
    output logic [width-1:0] done_pulse
);

    localparam int CW = $clog2(hold_cycles + 1);
    localparam logic [CW-1:0] CNT_HOLD = CW'(hold_cycles);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0]    cnt_q [width];
    logic [CW-1:0]    cnt_d [width];
    logic [width-1:0] accept_s;
    logic [width-1:0] done_q;
    logic [width-1:0] done_d;

    // Per-channel next-state: a pulse is only taken while idle unless retriggering is enabled
    always_comb begin
        for (int i = 0; i < width; i++) begin
            accept_s[i] = pulse_in[i] & (retrigger | (cnt_q[i] == CNT_ZERO));
            if (accept_s[i]) begin
                cnt_d[i] = CNT_HOLD;
            end else if (cnt_q[i] != CNT_ZERO) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end else begin
                cnt_d[i] = CNT_ZERO;
            end
            done_d[i]    = (cnt_q[i] == CNT_ONE) & ~accept_s[i];
            level_out[i] = (cnt_q[i] != CNT_ZERO);
        end
    end

    // Counter and completion-strobe registers; reset aborts a hold silently
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < width; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
            done_q <= {width{1'b0}};
        end else begin
            for (int i = 0; i < width; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            done_q <= done_d;
        end
    end

    assign done_pulse = done_q;

endmodule
